// File: rtl/chacha_block.sv
// ChaCha20 block-function engine: iterates the combinational round stage and adds the initial state.
// Optional macro CHACHA_DOUBLE_ROUND_EN chains two round stages so each cycle applies a double round.

module round (
  input  logic         op_type,
  input  logic [127:0] input_a,
  input  logic [127:0] input_b,
  input  logic [127:0] input_c,
  input  logic [127:0] input_d,
  output logic [127:0] output_a,
  output logic [127:0] output_b,
  output logic [127:0] output_c,
  output logic [127:0] output_d
);
  function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    logic [31:0] ta, tb, tc, td;
    ta = a + b;   td = d ^ ta;  td = {td[15:0], td[31:16]};
    tc = c + td;  tb = b ^ tc;  tb = {tb[19:0], tb[31:20]};
    ta = ta + tb; td = td ^ ta; td = {td[23:0], td[31:24]};
    tc = tc + td; tb = tb ^ tc; tb = {tb[24:0], tb[31:25]};
    return {td, tc, tb, ta};
  endfunction

  // Diagonal rounds rotate the b/c/d column picks by 1/2/3 relative to a.
  always_comb begin : qr_map
    logic [1:0]   bi, ci, di;
    logic [127:0] q;
    output_a = '0;
    output_b = '0;
    output_c = '0;
    output_d = '0;
    for (int i = 0; i < 4; i++) begin
      bi = op_type ? 2'(i + 1) : 2'(i);
      ci = op_type ? 2'(i + 2) : 2'(i);
      di = op_type ? 2'(i + 3) : 2'(i);
      q  = qr(input_a[32*i +: 32], input_b[32*bi +: 32],
              input_c[32*ci +: 32], input_d[32*di +: 32]);
      output_a[32*i  +: 32] = q[31:0];
      output_b[32*bi +: 32] = q[63:32];
      output_c[32*ci +: 32] = q[95:64];
      output_d[32*di +: 32] = q[127:96];
    end
  end
endmodule

module chacha_block #(
  parameter int NUM_ROUNDS = 20,
  parameter int CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         busy
);
  localparam logic [127:0] SIGMA = 128'h6b206574_79622d32_3320646e_61707865;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ADD, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [511:0]       work_q, work_d;
  logic [511:0]       init_q, init_d;
  logic [511:0]       ks_q, ks_d;
  logic               ov_q, ov_d;
  logic [511:0]       rnd_out;
  logic [511:0]       init_vec;

  // State layout {d, c, b, a}; word j of the block sits at bits [32j+31:32j].
  assign init_vec = {nonce, counter, key[255:128], key[127:0], SIGMA};

`ifdef CHACHA_DOUBLE_ROUND_EN
  localparam int ROUND_STEPS = NUM_ROUNDS / 2;
  logic [511:0] mid_st;

  round u_round_col (
    .op_type (1'b0),
    .input_a (work_q[127:0]),   .input_b (work_q[255:128]),
    .input_c (work_q[383:256]), .input_d (work_q[511:384]),
    .output_a(mid_st[127:0]),   .output_b(mid_st[255:128]),
    .output_c(mid_st[383:256]), .output_d(mid_st[511:384])
  );

  round u_round_diag (
    .op_type (1'b1),
    .input_a (mid_st[127:0]),    .input_b (mid_st[255:128]),
    .input_c (mid_st[383:256]),  .input_d (mid_st[511:384]),
    .output_a(rnd_out[127:0]),   .output_b(rnd_out[255:128]),
    .output_c(rnd_out[383:256]), .output_d(rnd_out[511:384])
  );
`else
  localparam int ROUND_STEPS = NUM_ROUNDS;

  round u_round (
    .op_type (cnt_q[0]),
    .input_a (work_q[127:0]),    .input_b (work_q[255:128]),
    .input_c (work_q[383:256]),  .input_d (work_q[511:384]),
    .output_a(rnd_out[127:0]),   .output_b(rnd_out[255:128]),
    .output_c(rnd_out[383:256]), .output_d(rnd_out[511:384])
  );
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUND_STEPS - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    init_d  = init_q;
    ks_d    = ks_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = init_vec;
          init_d  = init_vec;
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        work_d = rnd_out;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_ADD;
      end
      S_ADD: begin
        for (int j = 0; j < 16; j++) ks_d[32*j +: 32] = work_q[32*j +: 32] + init_q[32*j +: 32];
        ov_d    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      init_q  <= '0;
      ks_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      init_q  <= init_d;
      ks_q    <= ks_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign keystream = ks_q;
endmodule

// File: tb/tb_chacha_block.sv
// Directed-vector bench for chacha_block: RFC test vectors, backpressure, reset abort, back-to-back.
module tb_chacha_block;
  localparam int NR = 20;
`ifdef CHACHA_DOUBLE_ROUND_EN
  localparam int STEPS = NR / 2;
`else
  localparam int STEPS = NR;
`endif
  localparam int EXP_LAT     = STEPS + 1;
  localparam int EXP_SPACING = STEPS + 3;

  localparam logic [255:0] KEY1 = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                                   32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [95:0]  NONCE1 = {32'h00000000, 32'h4a000000, 32'h09000000};

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] keystream;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  chacha_block #(.NUM_ROUNDS(NR)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key      (key),
    .nonce    (nonce),
    .counter  (counter),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .keystream(keystream),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [511:0] ks, input int j);
    return ks[32*j +: 32];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (!out_valid) check_eq("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, a1, a2;
    logic [511:0] saved, ks1, ks2;
    logic prev_ready;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    key = '0; nonce = '0; counter = '0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_keystream", 32'(keystream == '0), 32'd1);

    // Vector 1 with backpressure
    key = KEY1; nonce = NONCE1; counter = 32'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("v1_busy",     32'(busy),     32'd1);
    check_eq("v1_in_ready", 32'(in_ready), 32'd0);
    wait_valid(n);
    check_eq("v1_latency", 32'(n), 32'(EXP_LAT));
    check_eq("v1_w0",  word(keystream, 0),  32'he4e7f110);
    check_eq("v1_w1",  word(keystream, 1),  32'h15593bd1);
    check_eq("v1_w2",  word(keystream, 2),  32'h1fdd0f50);
    check_eq("v1_w3",  word(keystream, 3),  32'hc47120a3);
    check_eq("v1_w12", word(keystream, 12), 32'hd19c12b5);
    check_eq("v1_w15", word(keystream, 15), 32'h4e3c50a2);
    saved = keystream;
    for (int i = 0; i < 10; i++) begin
      key = ~KEY1; in_valid = 1'b1;
      tick();
      check_eq("bp_in_ready",  32'(in_ready),  32'd0);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; key = KEY1;
    check_eq("bp_stable", 32'(keystream == saved), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("pop_out_valid", 32'(out_valid), 32'd0);
    check_eq("pop_in_ready",  32'(in_ready),  32'd1);
    tick();
    check_eq("pop_busy", 32'(busy), 32'd0);
    check_eq("pop_hold_w0", word(keystream, 0), 32'he4e7f110);

    // Reset mid-ROUND, with in_valid asserted alongside reset
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1; in_valid = 1'b1;
    tick();
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_in_ready",  32'(in_ready),  32'd1);
    check_eq("abort_keystream", 32'(keystream == '0), 32'd1);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check_eq("abort_no_capture", 32'(busy), 32'd0);

    // Vector 2: all zero
    key = '0; nonce = '0; counter = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    check_eq("v2_latency", 32'(n), 32'(EXP_LAT));
    check_eq("v2_w0", word(keystream, 0), 32'hade0b876);
    check_eq("v2_w1", word(keystream, 1), 32'h903df1a0);
    out_ready = 1'b1;
    tick();

    // Back-to-back; counter changes right after the first accept
    key = KEY1; nonce = NONCE1; counter = 32'd1; in_valid = 1'b1;
    tick();
    a1 = cyc;
    counter = 32'd2;
    wait_valid(n);
    ks1 = keystream;
    a2 = -1000;
    for (int i = 0; i < 10; i++) begin
      prev_ready = in_ready;
      tick();
      if (prev_ready && busy) begin
        a2 = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    check_eq("b2b_spacing", 32'(a2 - a1), 32'(EXP_SPACING));
    wait_valid(n);
    ks2 = keystream;
    tick();
    check_eq("b2b_blk1_w0",  word(ks1, 0),  32'he4e7f110);
    check_eq("b2b_blk1_w12", word(ks1, 12), 32'hd19c12b5);
    check_eq("b2b_w12_differs", 32'(word(ks2, 12) != word(ks1, 12)), 32'd1);
    check_eq("b2b_w0_differs",  32'(word(ks2, 0)  != word(ks1, 0)),  32'd1);
    check_eq("b2b_idle", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
